// File: rtl/bf16mul_issue_buf_if.sv
// Producer/consumer handshake bundle for the BF16 multiplier issue buffer.
// master = operand producer and result consumer side; slave = the buffer.
interface bf16mul_issue_buf_if #(
    parameter int unsigned TAG_W = 4
) ();
    logic             in_valid;
    logic             in_ready;
    logic [15:0]      in_a;
    logic [15:0]      in_b;
    logic [TAG_W-1:0] in_tag;
    logic             out_valid;
    logic             out_ready;
    logic [15:0]      out_data;
    logic [TAG_W-1:0] out_tag;

    modport master (
        output in_valid, in_a, in_b, in_tag, out_ready,
        input  in_ready, out_valid, out_data, out_tag
    );

    modport slave (
        input  in_valid, in_a, in_b, in_tag, out_ready,
        output in_ready, out_valid, out_data, out_tag
    );
endinterface

// File: rtl/bf16mul_issue_buf.sv
// Credit-protected issue/return buffer around a fixed-latency, non-stallable BF16 multiplier.
// Define BF16MUL_TAG_EN to carry in_tag through the pipeline and return it on out_tag.
module bf16mul_issue_buf #(
    parameter int unsigned DEPTH   = 4,
    parameter int unsigned LATENCY = 3,
    parameter int unsigned TAG_W   = 4
) (
    input  logic                clk,
    input  logic                rst,
    bf16mul_issue_buf_if.slave  bus,
    output logic                mul_valid_in,
    output logic [15:0]         mul_operand_a,
    output logic [15:0]         mul_operand_b,
    input  logic [15:0]         mul_result,
    input  logic                mul_valid_out,
    output logic                proto_err
);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);
    localparam int unsigned INF_W = $clog2(LATENCY + 1);
    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned SUM_W = CNT_W + 1;

    logic [INF_W-1:0]   inflight;
    logic [CNT_W-1:0]   count;
    logic [PTR_W-1:0]   wptr;
    logic [PTR_W-1:0]   rptr;
    logic [LATENCY-1:0] exp_v;
    logic [15:0]        mem_data [DEPTH];

    logic credit_ok;
    logic issue;
    logic wr;
    logic rd;
    logic drop;
    logic mismatch;
    logic head_valid;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (32'(p) == 32'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    // Every issued request owns a FIFO slot from issue until it is read out.
    assign credit_ok  = (SUM_W'(inflight) + SUM_W'(count)) < SUM_W'(DEPTH);
    assign issue      = bus.in_valid & credit_ok;
    assign head_valid = (count != '0);
    assign rd         = head_valid & bus.out_ready;

    // Results with nothing in flight cannot be ours: drop them rather than corrupt the FIFO.
    assign drop     = mul_valid_out & (inflight == '0);
    assign wr       = mul_valid_out & ~drop;
    assign mismatch = exp_v[LATENCY-1] ^ mul_valid_out;

    assign bus.in_ready  = credit_ok;
    assign bus.out_valid = head_valid;
    assign bus.out_data  = mem_data[rptr];

    assign mul_valid_in  = issue;
    assign mul_operand_a = bus.in_a;
    assign mul_operand_b = bus.in_b;

    always_ff @(posedge clk) begin
        if (rst) begin
            inflight  <= '0;
            count     <= '0;
            wptr      <= '0;
            rptr      <= '0;
            exp_v     <= '0;
            proto_err <= 1'b0;
        end else begin
            inflight <= inflight + INF_W'(issue) - INF_W'(wr);
            count    <= count + CNT_W'(wr) - CNT_W'(rd);
            exp_v    <= LATENCY'({exp_v, issue});
            if (wr) wptr <= ptr_inc(wptr);
            if (rd) rptr <= ptr_inc(rptr);
            if (mismatch || drop) proto_err <= 1'b1;
        end
    end

    // Storage needs no reset: count gates visibility of every entry.
    always_ff @(posedge clk) begin
        if (wr) mem_data[wptr] <= mul_result;
    end

`ifdef BF16MUL_TAG_EN
    logic [TAG_W-1:0] tag_sr  [LATENCY];
    logic [TAG_W-1:0] mem_tag [DEPTH];

    // Tag pipeline mirrors the multiplier latency so tag_sr[LATENCY-1] lines up with mul_valid_out.
    always_ff @(posedge clk) begin
        tag_sr[0] <= bus.in_tag;
        for (int i = 1; i < LATENCY; i++) begin
            tag_sr[i] <= tag_sr[i-1];
        end
        if (wr) mem_tag[wptr] <= tag_sr[LATENCY-1];
    end

    assign bus.out_tag = mem_tag[rptr];
`else
    logic unused_tag;
    assign unused_tag  = ^bus.in_tag;
    assign bus.out_tag = '0;
`endif

endmodule

// File: tb/tb_bf16mul_issue_buf.sv
// Bench for bf16mul_issue_buf: stand-in 3-stage multiplier plus queue-based reference model.
module tb_bf16mul_issue_buf;
    localparam int unsigned DEPTH   = 4;
    localparam int unsigned LATENCY = 3;
    localparam int unsigned TAG_W   = 4;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    bf16mul_issue_buf_if #(.TAG_W(TAG_W)) bus ();

    logic        mul_valid_in;
    logic [15:0] mul_operand_a;
    logic [15:0] mul_operand_b;
    logic [15:0] mul_result;
    logic        mul_valid_out;
    logic        proto_err;
    logic        spur;

    bf16mul_issue_buf #(.DEPTH(DEPTH), .LATENCY(LATENCY), .TAG_W(TAG_W)) dut (
        .clk           (clk),
        .rst           (rst),
        .bus           (bus),
        .mul_valid_in  (mul_valid_in),
        .mul_operand_a (mul_operand_a),
        .mul_operand_b (mul_operand_b),
        .mul_result    (mul_result),
        .mul_valid_out (mul_valid_out),
        .proto_err     (proto_err)
    );

    // Simple BF16 multiply: denormals flush to zero, truncating rounding.
    function automatic logic [15:0] bf_mul(input logic [15:0] a, input logic [15:0] b);
        logic       s;
        logic [7:0] ea, eb;
        logic [6:0] ma, mb, m;
        logic [15:0] p;
        int e;
        s = a[15] ^ b[15]; ea = a[14:7]; eb = b[14:7]; ma = a[6:0]; mb = b[6:0];
        if ((ea == 8'hFF && ma != 0) || (eb == 8'hFF && mb != 0)) return 16'h7FC0;
        if (ea == 8'hFF || eb == 8'hFF)
            return (ea == 8'h00 || eb == 8'h00) ? 16'h7FC0 : {s, 8'hFF, 7'h00};
        if (ea == 8'h00 || eb == 8'h00) return {s, 15'h0000};
        p = 16'({1'b1, ma}) * 16'({1'b1, mb});
        e = int'(ea) + int'(eb) - 127;
        if (p[15]) begin m = p[14:8]; e++; end
        else m = p[13:7];
        if (e >= 255) return {s, 8'hFF, 7'h00};
        if (e <= 0) return {s, 15'h0000};
        return {s, e[7:0], m};
    endfunction

    function automatic logic [TAG_W-1:0] tag_of(input logic [TAG_W-1:0] t);
`ifdef BF16MUL_TAG_EN
        return t;
`else
        return t & '0;
`endif
    endfunction

    // Stand-in multiplier: three register stages, reset together with the DUT.
    logic        v1, v2, v3;
    logic [15:0] d1, d2, d3;
    always @(posedge clk) begin
        if (rst) begin
            v1 <= 1'b0; v2 <= 1'b0; v3 <= 1'b0;
        end else begin
            v1 <= mul_valid_in; v2 <= v1; v3 <= v2;
            d1 <= bf_mul(mul_operand_a, mul_operand_b); d2 <= d1; d3 <= d2;
        end
    end
    assign mul_valid_out = v3 | spur;
    assign mul_result    = d3;

    int checks = 0;
    int passes = 0;
    int cyc    = 0;

    // A legitimate multiplier result must never arrive while the FIFO is full.
    always @(posedge clk) begin
        if (!rst && v3) begin
            checks++;
            if (dut.count == 3'(DEPTH)) $display("FAIL write_at_full cyc=%0d count got %0d want <%0d", cyc, dut.count, DEPTH);
            else passes++;
        end
    end

    typedef struct {
        logic [15:0]      d;
        logic [TAG_W-1:0] t;
        int               due;
    } ent_t;
    ent_t q[$];
    logic e_err;

    logic             o_ready, o_valid, o_mvi, o_err;
    logic [15:0]      o_data;
    logic [TAG_W-1:0] o_tag;
    logic             e_ready, e_valid, e_mvi;
    logic [15:0]      e_data;
    logic [TAG_W-1:0] e_tag;

    // One clock: drive inputs, snapshot DUT and model expectations, then advance the model.
    task automatic drive_cycle(input logic v, input logic [15:0] a, input logic [15:0] b,
                               input logic [TAG_W-1:0] t, input logic rdy, input logic sp);
        logic acc, rdo;
        ent_t e;
        @(negedge clk);
        bus.in_valid = v; bus.in_a = a; bus.in_b = b; bus.in_tag = t;
        bus.out_ready = rdy; spur = sp;
        #1;
        o_ready = bus.in_ready; o_valid = bus.out_valid; o_data = bus.out_data;
        o_tag = bus.out_tag; o_mvi = mul_valid_in; o_err = proto_err;
        e_ready = (q.size() < int'(DEPTH));
        e_valid = (q.size() > 0) && (q[0].due <= cyc);
        e_data  = e_valid ? q[0].d : 16'h0;
        e_tag   = e_valid ? q[0].t : '0;
        e_mvi   = v & e_ready;
        acc = v & e_ready;
        rdo = rdy & e_valid;
        @(posedge clk);
        cyc++;
        if (rdo) void'(q.pop_front());
        if (acc) begin
            e.d = bf_mul(a, b); e.t = tag_of(t); e.due = cyc + int'(LATENCY);
            q.push_back(e);
        end
        if (sp) e_err = 1'b1;
        #1 spur = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; bus.in_valid = 1'b0; bus.out_ready = 1'b0; spur = 1'b0;
        @(posedge clk);
        cyc++;
        q.delete();
        e_err = 1'b0;
        #1 rst = 1'b0;
    endtask

    task automatic idle(input logic rdy);
        drive_cycle(1'b0, 16'h0, 16'h0, '0, rdy, 1'b0);
    endtask

    task automatic test_reset();
        do_reset();
        idle(1'b0);
        checks++; if (o_valid !== 1'b0) $display("FAIL reset_out_valid got %b want 0", o_valid); else passes++;
        checks++; if (o_ready !== 1'b1) $display("FAIL reset_in_ready got %b want 1", o_ready); else passes++;
        checks++; if (o_err !== 1'b0) $display("FAIL reset_proto_err got %b want 0", o_err); else passes++;
        checks++; if (o_mvi !== 1'b0) $display("FAIL reset_mul_valid_in got %b want 0", o_mvi); else passes++;
        checks++; if (dut.count !== 3'd0) $display("FAIL reset_count got %0d want 0", dut.count); else passes++;
    endtask

    task automatic test_single();
        int rise = -1;
        logic [15:0] got_d = 16'h0;
        logic [TAG_W-1:0] got_t = '0;
        drive_cycle(1'b1, 16'h3F80, 16'h4000, 4'd5, 1'b1, 1'b0);
        checks++; if (o_mvi !== 1'b1) $display("FAIL single_issue mul_valid_in got %b want 1", o_mvi); else passes++;
        for (int i = 1; i <= 7; i++) begin
            idle(1'b1);
            if (o_valid === 1'b1 && rise < 0) begin rise = i; got_d = o_data; got_t = o_tag; end
        end
        checks++; if (rise != 4) $display("FAIL single_latency got %0d want 4", rise); else passes++;
        checks++; if (got_d !== 16'h4000) $display("FAIL single_data got %h want 4000", got_d); else passes++;
        checks++; if (got_t !== tag_of(4'd5)) $display("FAIL single_tag got %0d want %0d", got_t, tag_of(4'd5)); else passes++;
    endtask

    task automatic test_back_to_back();
        logic [15:0] va [3];
        logic [15:0] vb [3];
        logic [15:0] want [3];
        logic [15:0] got [$];
        va = '{16'h3FC0, 16'h7F80, 16'hC000};
        vb = '{16'h3FC0, 16'h0000, 16'h4040};
        want = '{16'h4010, 16'h7FC0, 16'hC0C0};
        for (int i = 0; i < 11; i++) begin
            if (i < 3) drive_cycle(1'b1, va[i], vb[i], TAG_W'(i), 1'b1, 1'b0);
            else idle(1'b1);
            checks++; if (o_ready !== 1'b1) $display("FAIL b2b_in_ready cyc=%0d got %b want 1", i, o_ready); else passes++;
            if (o_valid === 1'b1) got.push_back(o_data);
        end
        checks++; if (got.size() != 3) $display("FAIL b2b_count got %0d want 3", got.size()); else passes++;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (got.size() <= i || got[i] !== want[i])
                $display("FAIL b2b_data%0d got %h want %h", i, (got.size() > i) ? got[i] : 16'hxxxx, want[i]);
            else passes++;
        end
    endtask

    task automatic test_credit_stall();
        int n_acc = 0;
        for (int i = 0; i < 8; i++) begin
            drive_cycle(1'b1, 16'($urandom), 16'($urandom), TAG_W'($urandom), 1'b0, 1'b0);
            if (o_ready === 1'b1) n_acc++;
        end
        #1;
        checks++; if (n_acc != 4) $display("FAIL stall_accepts got %0d want 4", n_acc); else passes++;
        checks++; if (o_ready !== 1'b0) $display("FAIL stall_in_ready got %b want 0", o_ready); else passes++;
        checks++; if (dut.count !== 3'd4) $display("FAIL stall_count got %0d want 4", dut.count); else passes++;
        drive_cycle(1'b1, 16'($urandom), 16'($urandom), TAG_W'($urandom), 1'b1, 1'b0);
        checks++; if (o_data !== e_data) $display("FAIL stall_head got %h want %h", o_data, e_data); else passes++;
        n_acc = 0;
        for (int i = 0; i < 6; i++) begin
            drive_cycle(1'b1, 16'($urandom), 16'($urandom), TAG_W'($urandom), 1'b0, 1'b0);
            if (o_mvi === 1'b1) n_acc++;
        end
        checks++; if (n_acc != 1) $display("FAIL stall_one_credit got %0d want 1", n_acc); else passes++;
        for (int i = 0; i < 10; i++) begin
            idle(1'b1);
            checks++; if (o_valid !== e_valid) $display("FAIL drain_valid cyc=%0d got %b want %b", cyc, o_valid, e_valid); else passes++;
            if (e_valid) begin
                checks++; if (o_data !== e_data) $display("FAIL drain_data cyc=%0d got %h want %h", cyc, o_data, e_data); else passes++;
            end
        end
        checks++; if (o_valid !== 1'b0) $display("FAIL drain_empty got %b want 0", o_valid); else passes++;
    endtask

    // Fill to DEPTH, then stream with out_ready high so writes and reads overlap at high and low occupancy.
    task automatic test_overlap();
        for (int i = 0; i < 40; i++) begin
            drive_cycle((i < 4) || (i >= 8 && i < 30), 16'($urandom), 16'($urandom), TAG_W'($urandom),
                        (i >= 8), 1'b0);
            checks++; if (o_ready !== e_ready) $display("FAIL ovl_in_ready cyc=%0d got %b want %b", cyc, o_ready, e_ready); else passes++;
            checks++; if (o_valid !== e_valid) $display("FAIL ovl_valid cyc=%0d got %b want %b", cyc, o_valid, e_valid); else passes++;
            if (e_valid) begin
                checks++; if (o_data !== e_data) $display("FAIL ovl_data cyc=%0d got %h want %h", cyc, o_data, e_data); else passes++;
                checks++; if (o_tag !== e_tag) $display("FAIL ovl_tag cyc=%0d got %0d want %0d", cyc, o_tag, e_tag); else passes++;
            end
        end
    endtask

    task automatic test_spurious();
        idle(1'b1);
        drive_cycle(1'b0, 16'h0, 16'h0, '0, 1'b1, 1'b1);
        for (int i = 0; i < 4; i++) begin
            idle(1'b1);
            checks++; if (o_valid !== 1'b0) $display("FAIL spur_out_valid i=%0d got %b want 0", i, o_valid); else passes++;
            checks++; if (o_err !== e_err) $display("FAIL spur_proto_err i=%0d got %b want %b", i, o_err, e_err); else passes++;
        end
        checks++; if (dut.count !== 3'd0) $display("FAIL spur_count got %0d want 0", dut.count); else passes++;
        do_reset();
        idle(1'b0);
        checks++; if (o_err !== 1'b0) $display("FAIL spur_clear got %b want 0", o_err); else passes++;
    endtask

    task automatic test_reset_midflight();
        for (int i = 0; i < 6; i++) begin
            drive_cycle(i < 2, 16'($urandom), 16'($urandom), TAG_W'($urandom), 1'b0, 1'b0);
        end
        drive_cycle(1'b1, 16'($urandom), 16'($urandom), '0, 1'b0, 1'b0);
        drive_cycle(1'b1, 16'($urandom), 16'($urandom), '0, 1'b0, 1'b0);
        #1;
        checks++; if (dut.count !== 3'd2) $display("FAIL mid_buffered got %0d want 2", dut.count); else passes++;
        checks++; if (dut.inflight !== 2'd2) $display("FAIL mid_inflight got %0d want 2", dut.inflight); else passes++;
        do_reset();
        for (int i = 0; i < 8; i++) begin
            idle(1'b1);
            checks++; if (o_valid !== 1'b0) $display("FAIL mid_stale i=%0d got %b want 0", i, o_valid); else passes++;
            if (i == 0) begin
                checks++; if (o_ready !== 1'b1) $display("FAIL mid_in_ready got %b want 1", o_ready); else passes++;
                checks++; if (o_err !== 1'b0) $display("FAIL mid_proto_err got %b want 0", o_err); else passes++;
            end
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            drive_cycle(($urandom_range(0, 3) != 0), 16'($urandom), 16'($urandom), TAG_W'($urandom),
                        (i >= 380) || ($urandom_range(0, 9) < 6), 1'b0);
            checks++; if (o_ready !== e_ready) $display("FAIL rnd_in_ready cyc=%0d got %b want %b", cyc, o_ready, e_ready); else passes++;
            checks++; if (o_mvi !== e_mvi) $display("FAIL rnd_mul_valid_in cyc=%0d got %b want %b", cyc, o_mvi, e_mvi); else passes++;
            checks++; if (o_valid !== e_valid) $display("FAIL rnd_valid cyc=%0d got %b want %b", cyc, o_valid, e_valid); else passes++;
            checks++; if (o_err !== 1'b0) $display("FAIL rnd_proto_err cyc=%0d got %b want 0", cyc, o_err); else passes++;
            if (e_valid) begin
                checks++; if (o_data !== e_data) $display("FAIL rnd_data cyc=%0d got %h want %h", cyc, o_data, e_data); else passes++;
                checks++; if (o_tag !== e_tag) $display("FAIL rnd_tag cyc=%0d got %0d want %0d", cyc, o_tag, e_tag); else passes++;
            end
        end
    endtask

    initial begin
        rst = 1'b1; spur = 1'b0; e_err = 1'b0;
        bus.in_valid = 1'b0; bus.in_a = '0; bus.in_b = '0; bus.in_tag = '0; bus.out_ready = 1'b0;
        test_reset();
        test_single();
        test_back_to_back();
        test_credit_stall();
        test_overlap();
        test_spurious();
        test_reset_midflight();
        test_random();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout cyc=%0d got no finish want finish", cyc);
        $fatal(1);
    end
endmodule
